// File: rtl/mac_pkg.sv
// mac_pkg: shared default widths, FSM state encoding and saturation limits for the MAC lane.
package mac_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_ACC_W  = 40;
  typedef enum logic [1:0] {ACC, FLUSH, OUT} state_t;
  localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};
endpackage

// File: rtl/mac_accum_sat_round.sv
// sat_round: rescale an ACC_W fixed-point sum to DATA_W with saturation flag.
// MAC_ROUND_EN adds a half-LSB before the shift (round half up); otherwise truncates toward -inf.
module sat_round import mac_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic        [DATA_W-1:0] data,
  output logic                     sat
);
  logic signed [ACC_W-1:0] rs, r;
  logic [ACC_W-DATA_W:0] hi;
`ifdef MAC_ROUND_EN
  assign rs = sum + (ACC_W'(1) << (FRAC_W-1));
`else
  assign rs = sum;
`endif
  assign r = rs >>> FRAC_W;
  // result fits only if every bit above the DATA_W sign bit matches it
  assign hi = r[ACC_W-1:DATA_W-1];
  assign sat = !(&hi || !(|hi));
  assign data = sat ? {r[ACC_W-1], {(DATA_W-1){~r[ACC_W-1]}}} : r[DATA_W-1:0];
endmodule

// File: rtl/mac_accum.sv
// mac_accum: streaming biased multiply-accumulate with rescale/saturate, valid/ready on both sides.
module mac_accum import mac_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_act,
  input  logic signed [DATA_W-1:0] in_wgt,
  input  logic signed [DATA_W-1:0] in_bias,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] out_data,
  output logic                     out_sat
);
  state_t state, nxt;
  logic first, pv, p_first, accept, sr_sat;
  logic signed [2*DATA_W-1:0] p_q;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0] acc, s;
  logic [DATA_W-1:0] sr_data;
  assign accept = in_valid && in_ready;
  // first beat of a vector restarts from the bias instead of the running sum
  assign s = (p_first ? ACC_W'(bias_q) <<< FRAC_W : acc) + ACC_W'(p_q);
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == ACC ? (accept && in_last ? FLUSH : ACC) :
          state == FLUSH ? OUT : (out_ready ? ACC : OUT);
  end
  always_comb begin
    in_ready = state == ACC;
    out_valid = state == OUT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      first <= 1'b1;
      pv <= 1'b0;
      p_first <= 1'b0;
      p_q <= '0;
      bias_q <= '0;
      acc <= '0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      pv <= accept;
      if (accept) begin
        p_q <= in_act * in_wgt;
        p_first <= first;
        bias_q <= in_bias;
      end
      if (pv) acc <= s;
      if (state == FLUSH) begin
        out_data <= sr_data;
        out_sat <= sr_sat;
      end
      first <= (out_valid && out_ready) ? 1'b1 : accept ? 1'b0 : first;
    end
  end
  sat_round #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_sat (
    .sum(s), .data(sr_data), .sat(sr_sat)
  );
endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed vectors with a result scoreboard drained by an output monitor.
module tb_mac_accum;
  import mac_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [15:0] in_act = 0, in_wgt = 0, in_bias = 0;
  logic in_ready, out_valid, out_sat;
  logic [15:0] out_data;
  int n_cmp = 0, n_bad = 0;
  logic [16:0] exp_q[$];

  mac_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: every output handshake consumes one scoreboard entry
  always @(negedge clk) begin : monitor
    logic [16:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %h want none", {out_sat, out_data});
      end else begin
        e = exp_q.pop_front();
        chk("result", {15'd0, out_sat, out_data}, {15'd0, e});
      end
    end
  end

  task automatic beat(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b, input logic l);
    in_valid = 1; in_act = a; in_wgt = w; in_bias = b; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic finish_out();
    wait_valid();
    @(posedge clk); #1;
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    rst = 0;
    // 3 x (1.0*2.0) + 0.5 = 6.5
    exp_q.push_back({1'b0, 16'h0680});
    beat(16'h0100, 16'h0200, 16'h0080, 0);
    beat(16'h0100, 16'h0200, 16'h0080, 0);
    beat(16'h0100, 16'h0200, 16'h0080, 1);
    chk("lat_t1", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("lat_t2", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({1'b1, SAT_MAX});
    repeat (3) beat(16'h7FFF, 16'h7FFF, 16'h0000, 0);
    beat(16'h7FFF, 16'h7FFF, 16'h0000, 1);
    finish_out();
    exp_q.push_back({1'b1, SAT_MIN});
    repeat (3) beat(16'h8000, 16'h7FFF, 16'h0000, 0);
    beat(16'h8000, 16'h7FFF, 16'h0000, 1);
    finish_out();
`ifdef MAC_ROUND_EN
    exp_q.push_back({1'b0, 16'h0001});
`else
    exp_q.push_back({1'b0, 16'h0000});
`endif
    beat(16'h0001, 16'h0080, 16'h0000, 1);
    finish_out();
`ifdef MAC_ROUND_EN
    exp_q.push_back({1'b0, 16'h0000});
`else
    exp_q.push_back({1'b0, 16'hFFFF});
`endif
    beat(16'hFFFF, 16'h0080, 16'h0000, 1);
    finish_out();
    // backpressure: 2 x 3.0*1.0 = 6.0 held for 5 cycles
    out_ready = 0;
    exp_q.push_back({1'b0, 16'h0600});
    beat(16'h0300, 16'h0100, 16'h0000, 0);
    beat(16'h0300, 16'h0100, 16'h0000, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_data", {16'd0, out_data}, 32'h0600);
      chk("bp_sat", {31'd0, out_sat}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("in_ready_after_bp", {31'd0, in_ready}, 32'd1);
    // bias isolation: 1 + 1.0 + 2.0 = 4.0, then -1 + 2.0 + 1.0 = 2.0
    exp_q.push_back({1'b0, 16'h0400});
    beat(16'h0100, 16'h0100, 16'h0100, 0);
    beat(16'h0200, 16'h0100, 16'h7000, 1);
    finish_out();
    exp_q.push_back({1'b0, 16'h0200});
    beat(16'h0200, 16'h0100, 16'hFF00, 0);
    beat(16'h0100, 16'h0100, 16'h1234, 1);
    finish_out();
    // reset mid-vector discards the partial sum
    beat(16'h1000, 16'h0100, 16'h0100, 0);
    beat(16'h1000, 16'h0100, 16'h0100, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {16'd0, out_data}, 32'd0);
    exp_q.push_back({1'b0, 16'h0100});
    beat(16'h0100, 16'h0100, 16'h0000, 1);
    finish_out();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
